// File: rtl/layer2_ctrl.sv
// Layer-2 conv sequencer: weight/feature read addressing, map enables and pooled-result counting.
// Define LAYER2_CTRL_TIMEOUT_EN to compile in the WAIT_DONE watchdog that drives err.
module layer2_ctrl #(
  parameter int unsigned NUM_MAPS    = 6,
  parameter int unsigned KERNEL_TAPS = 25,
  parameter int unsigned MAP_PIXELS  = 144,
  parameter int unsigned NUM_RESULTS = 16,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                finish,
  input  logic                save,
  output logic [7:0]          w_addr,
  output logic [NUM_MAPS-1:0] w_en,
  output logic [7:0]          f_addr,
  output logic                m_en,
  output logic                out_we,
  output logic [3:0]          out_addr,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned CntW = $clog2(NUM_RESULTS + 1);
  localparam int unsigned TapW = $clog2(KERNEL_TAPS);
  localparam logic [7:0]      WLast   = 8'(NUM_MAPS * KERNEL_TAPS - 1);
  localparam logic [7:0]      FLast   = 8'(MAP_PIXELS - 1);
  localparam logic [TapW-1:0] TapLast = TapW'(KERNEL_TAPS - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(NUM_RESULTS);

  typedef enum logic [1:0] {StIdle, StLoadW, StStream, StWaitDone} state_e;

  state_e              r_state;
  state_e              w_next_state;
  logic [7:0]          r_w_addr;
  logic [TapW-1:0]     r_tap;
  logic [NUM_MAPS-1:0] r_sel;
  logic [NUM_MAPS-1:0] r_w_en;
  logic [7:0]          r_f_addr;
  logic                r_m_en;
  logic [CntW-1:0]     r_count;
  logic                r_fin_seen;
  logic                r_done;

  logic            w_start;
  logic            w_save_ok;
  logic [CntW-1:0] w_count_next;
  logic            w_exit;
  logic            w_wd_expire;

  assign w_start      = (r_state == StIdle) && start;
  assign w_save_ok    = save && (r_state != StIdle) && (r_count < CntMax);
  assign w_count_next = r_count + CntW'(w_save_ok);
  // Current-cycle finish/save count toward the exit so done lands one cycle later.
  assign w_exit       = (r_fin_seen || (finish && (r_state != StIdle))) &&
                        (w_count_next == CntMax);

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      StIdle:     if (start) w_next_state = StLoadW;
      StLoadW:    if (r_w_addr == WLast) w_next_state = StStream;
      StStream:   if (r_f_addr == FLast) w_next_state = StWaitDone;
      StWaitDone: if (r_done) w_next_state = StIdle;
      default:    w_next_state = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_w_addr   <= '0;
      r_tap      <= '0;
      r_sel      <= '0;
      r_w_en     <= '0;
      r_f_addr   <= '0;
      r_m_en     <= 1'b0;
      r_count    <= '0;
      r_fin_seen <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // ROM data trails its address by one cycle, so the enables are the delayed map select.
      r_w_en  <= (r_state == StLoadW) ? r_sel : '0;
      r_m_en  <= (r_state == StStream);

      if (w_start) begin
        r_w_addr <= '0;
        r_tap    <= '0;
        r_sel    <= NUM_MAPS'(1);
      end else if (r_state == StLoadW) begin
        r_w_addr <= (r_w_addr == WLast) ? 8'd0 : r_w_addr + 8'd1;
        if (r_tap == TapLast) begin
          r_tap <= '0;
          r_sel <= {r_sel[NUM_MAPS-2:0], 1'b0};
        end else begin
          r_tap <= r_tap + TapW'(1);
        end
      end

      if (r_state == StStream) begin
        r_f_addr <= (r_f_addr == FLast) ? 8'd0 : r_f_addr + 8'd1;
      end

      if (w_start) begin
        r_count <= '0;
      end else if (w_save_ok) begin
        r_count <= w_count_next;
      end

      if (w_start) begin
        r_fin_seen <= 1'b0;
      end else if (finish && (r_state != StIdle)) begin
        r_fin_seen <= 1'b1;
      end

      r_done <= (r_state == StWaitDone) && !r_done && (w_exit || w_wd_expire);
    end
  end

`ifdef LAYER2_CTRL_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  logic [WdW-1:0] r_wd;
  logic           r_err;

  assign w_wd_expire = (r_state == StWaitDone) && !r_done && (r_wd == WdW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if ((r_state == StWaitDone) && !r_done) begin
        r_wd <= r_wd + WdW'(1);
      end else begin
        r_wd <= '0;
      end
      if (w_start) begin
        r_err <= 1'b0;
      end else if (w_wd_expire && !w_exit) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  // TIMEOUT only matters when the watchdog is built in.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_wd_expire      = 1'b0;
  assign err              = 1'b0;
`endif

  assign w_addr   = r_w_addr;
  assign w_en     = r_w_en;
  assign f_addr   = r_f_addr;
  assign m_en     = r_m_en;
  assign out_we   = w_save_ok;
  assign out_addr = 4'(r_count);
  assign busy     = (r_state != StIdle);
  assign done     = r_done;

endmodule

// File: tb/tb_layer2_ctrl.sv
// Self-checking bench for layer2_ctrl: timing vector table, address/enable sweeps,
// save scoreboard, mid-pass reset, and the wait-state behaviour with or without the watchdog.
`timescale 1ns/1ps
module tb_layer2_ctrl;

`ifdef LAYER2_CTRL_TIMEOUT_EN
  localparam int unsigned TimeoutCyc = 8;
  localparam int          Pass3Last  = 303;
`else
  localparam int unsigned TimeoutCyc = 4096;
  localparam int          Pass3Last  = 320;
`endif

  logic       clk, reset, start, finish, save;
  logic [7:0] w_addr, f_addr;
  logic [5:0] w_en;
  logic       m_en, out_we, busy, done, err;
  logic [3:0] out_addr;

  int n_checks = 0;
  int n_fails  = 0;
  int sb_cnt   = 0;
  int exp_q[$];

  typedef struct {
    int         cyc;
    logic       start;
    logic       finish;
    logic       cw;
    logic [7:0] w_addr;
    logic [5:0] w_en;
    logic       cf;
    logic [7:0] f_addr;
    logic       m_en;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  layer2_ctrl #(
    .NUM_MAPS   (6),
    .KERNEL_TAPS(25),
    .MAP_PIXELS (144),
    .NUM_RESULTS(16),
    .TIMEOUT    (TimeoutCyc)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .finish  (finish),
    .save    (save),
    .w_addr  (w_addr),
    .w_en    (w_en),
    .f_addr  (f_addr),
    .m_en    (m_en),
    .out_we  (out_we),
    .out_addr(out_addr),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the end of the test");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag, input int cyc);
    check({tag, ".w_addr"}, cyc, 32'(w_addr), 32'd0);
    check({tag, ".w_en"}, cyc, 32'(w_en), 32'd0);
    check({tag, ".f_addr"}, cyc, 32'(f_addr), 32'd0);
    check({tag, ".m_en"}, cyc, 32'(m_en), 32'd0);
    check({tag, ".out_we"}, cyc, 32'(out_we), 32'd0);
    check({tag, ".out_addr"}, cyc, 32'(out_addr), 32'd0);
    check({tag, ".busy"}, cyc, 32'(busy), 32'd0);
    check({tag, ".done"}, cyc, 32'(done), 32'd0);
    check({tag, ".err"}, cyc, 32'(err), 32'd0);
  endtask

  // Raise save for the current cycle; the expected write address is queued first.
  task automatic do_save(input int cyc);
    logic exp_we;
    int   tmp;
    exp_we = (sb_cnt < 16);
    save   = 1'b1;
    if (exp_we) exp_q.push_back(sb_cnt);
    #1;
    check("out_we", cyc, 32'(out_we), 32'(exp_we));
    if (out_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL out_we @cycle %0d: strobe with no expected write", cyc);
      end else begin
        check("out_addr", cyc, 32'(out_addr), 32'(exp_q.pop_front()));
      end
    end else if (exp_we && exp_q.size() > 0) begin
      tmp = exp_q.pop_back();
    end
    if (exp_we) sb_cnt++;
  endtask

  task automatic add_vec(input int c, input logic st, input logic fi, input logic cw,
                         input logic [7:0] wa, input logic [5:0] we, input logic cf,
                         input logic [7:0] fa, input logic me, input logic bz,
                         input logic dn);
    vec_t v;
    v.cyc = c; v.start = st; v.finish = fi; v.cw = cw; v.w_addr = wa; v.w_en = we;
    v.cf = cf; v.f_addr = fa; v.m_en = me; v.busy = bz; v.done = dn;
    vecs.push_back(v);
  endtask

  function automatic logic is_save_cycle(input int c);
    return ((c >= 160) && (c <= 190) && (c % 2 == 0)) || (c == 298);
  endfunction

  initial begin
    int vi;
    vi = 0;
    //      cyc  st    fi    cw    w_addr  w_en      cf    f_addr  m_en  busy  done
    add_vec(0,   1'b0, 1'b0, 1'b1, 8'd0,   6'h00,    1'b0, 8'd0,   1'b0, 1'b1, 1'b0);
    add_vec(1,   1'b0, 1'b0, 1'b1, 8'd1,   6'h01,    1'b0, 8'd0,   1'b0, 1'b1, 1'b0);
    add_vec(25,  1'b0, 1'b0, 1'b1, 8'd25,  6'h01,    1'b0, 8'd0,   1'b0, 1'b1, 1'b0);
    add_vec(26,  1'b0, 1'b0, 1'b1, 8'd26,  6'h02,    1'b0, 8'd0,   1'b0, 1'b1, 1'b0);
    add_vec(50,  1'b0, 1'b0, 1'b1, 8'd50,  6'h02,    1'b0, 8'd0,   1'b0, 1'b1, 1'b0);
    add_vec(51,  1'b0, 1'b0, 1'b1, 8'd51,  6'h04,    1'b0, 8'd0,   1'b0, 1'b1, 1'b0);
    add_vec(76,  1'b0, 1'b0, 1'b1, 8'd76,  6'h08,    1'b0, 8'd0,   1'b0, 1'b1, 1'b0);
    add_vec(101, 1'b0, 1'b0, 1'b1, 8'd101, 6'h10,    1'b0, 8'd0,   1'b0, 1'b1, 1'b0);
    add_vec(126, 1'b0, 1'b0, 1'b1, 8'd126, 6'h20,    1'b0, 8'd0,   1'b0, 1'b1, 1'b0);
    add_vec(149, 1'b0, 1'b0, 1'b1, 8'd149, 6'h20,    1'b0, 8'd0,   1'b0, 1'b1, 1'b0);
    add_vec(150, 1'b0, 1'b0, 1'b0, 8'd0,   6'h20,    1'b1, 8'd0,   1'b0, 1'b1, 1'b0);
    add_vec(151, 1'b0, 1'b0, 1'b0, 8'd0,   6'h00,    1'b1, 8'd1,   1'b1, 1'b1, 1'b0);
    add_vec(200, 1'b1, 1'b0, 1'b0, 8'd0,   6'h00,    1'b1, 8'd50,  1'b1, 1'b1, 1'b0);
    add_vec(201, 1'b0, 1'b0, 1'b0, 8'd0,   6'h00,    1'b1, 8'd51,  1'b1, 1'b1, 1'b0);
    add_vec(293, 1'b0, 1'b0, 1'b0, 8'd0,   6'h00,    1'b1, 8'd143, 1'b1, 1'b1, 1'b0);
    add_vec(294, 1'b0, 1'b0, 1'b0, 8'd0,   6'h00,    1'b0, 8'd0,   1'b1, 1'b1, 1'b0);
    add_vec(295, 1'b0, 1'b0, 1'b0, 8'd0,   6'h00,    1'b0, 8'd0,   1'b0, 1'b1, 1'b0);
    add_vec(300, 1'b0, 1'b1, 1'b0, 8'd0,   6'h00,    1'b0, 8'd0,   1'b0, 1'b1, 1'b0);
    add_vec(301, 1'b0, 1'b0, 1'b0, 8'd0,   6'h00,    1'b0, 8'd0,   1'b0, 1'b1, 1'b1);
    add_vec(302, 1'b0, 1'b0, 1'b0, 8'd0,   6'h00,    1'b0, 8'd0,   1'b0, 1'b0, 1'b0);

    reset = 1'b1; start = 1'b0; finish = 1'b0; save = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_all_zero("idle", i);
    end

    // Pass 1: full sequence with 16 saves, a stray start and a late finish.
    start = 1'b1; sb_cnt = 0;
    step();
    for (int c = 0; c <= 302; c++) begin
      start = 1'b0; finish = 1'b0; save = 1'b0;
      if (vi < vecs.size() && vecs[vi].cyc == c) begin
        if (vecs[vi].cw) check("vec.w_addr", c, 32'(w_addr), 32'(vecs[vi].w_addr));
        if (vecs[vi].cf) check("vec.f_addr", c, 32'(f_addr), 32'(vecs[vi].f_addr));
        check("vec.w_en", c, 32'(w_en), 32'(vecs[vi].w_en));
        check("vec.m_en", c, 32'(m_en), 32'(vecs[vi].m_en));
        check("vec.busy", c, 32'(busy), 32'(vecs[vi].busy));
        check("vec.done", c, 32'(done), 32'(vecs[vi].done));
        check("vec.err", c, 32'(err), 32'd0);
        start  = vecs[vi].start;
        finish = vecs[vi].finish;
        vi++;
      end
      if (c <= 149) check("w_addr_seq", c, 32'(w_addr), 32'(c));
      if (c >= 150 && c <= 293) check("f_addr_seq", c, 32'(f_addr), 32'(c - 150));
      check("m_en_seq", c, 32'(m_en), 32'((c >= 151) && (c <= 294)));
      check("w_en_seq", c, 32'(w_en),
            (c >= 1 && c <= 150) ? (32'd1 << ((c - 1) / 25)) : 32'd0);
      if (is_save_cycle(c)) begin
        do_save(c);
      end else begin
        #1;
        check("out_we_quiet", c, 32'(out_we), 32'd0);
      end
      if (c < 302) step();
    end

    // Pass 2: back-to-back start clears the save count; reset at w_addr=60 aborts.
    start = 1'b0; finish = 1'b0; save = 1'b0;
    start = 1'b1; sb_cnt = 0;
    step();
    start = 1'b0;
    check("p2.w_addr", 0, 32'(w_addr), 32'd0);
    check("p2.busy", 0, 32'(busy), 32'd1);
    for (int c = 1; c <= 60; c++) begin
      step();
      save = 1'b0;
      check("p2.w_addr_seq", c, 32'(w_addr), 32'(c));
      if (c == 5 || c == 6) do_save(c);
    end
    save = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0; sb_cnt = 0;
    check_all_zero("after_reset", 61);
    step();
    check("post_reset.busy", 62, 32'(busy), 32'd0);
    check("post_reset.done", 62, 32'(done), 32'd0);

    // Pass 3: restart from zero, then no saves and no finish.
    start = 1'b1;
    step();
    start = 1'b0;
    check("p3.w_addr0", 0, 32'(w_addr), 32'd0);
    check("p3.busy0", 0, 32'(busy), 32'd1);
    step();
    check("p3.w_addr1", 1, 32'(w_addr), 32'd1);
    check("p3.w_en1", 1, 32'(w_en), 32'h01);
    for (int c = 2; c <= Pass3Last; c++) begin
      step();
`ifdef LAYER2_CTRL_TIMEOUT_EN
      if (c == 301) begin
        check("wd.done_early", c, 32'(done), 32'd0);
        check("wd.err_early", c, 32'(err), 32'd0);
      end
      if (c == 302) begin
        check("wd.done", c, 32'(done), 32'd1);
        check("wd.err", c, 32'(err), 32'd1);
        check("wd.busy", c, 32'(busy), 32'd1);
      end
      if (c == 303) begin
        check("wd.idle_busy", c, 32'(busy), 32'd0);
        check("wd.err_sticky", c, 32'(err), 32'd1);
        check("wd.done_pulse", c, 32'(done), 32'd0);
      end
`else
      if (c >= 295) begin
        check("wait.done", c, 32'(done), 32'd0);
        check("wait.busy", c, 32'(busy), 32'd1);
        check("wait.err", c, 32'(err), 32'd0);
      end
`endif
    end
`ifdef LAYER2_CTRL_TIMEOUT_EN
    start = 1'b1;
    step();
    start = 1'b0;
    check("wd.err_cleared", 0, 32'(err), 32'd0);
    check("wd.restart_busy", 0, 32'(busy), 32'd1);
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_all_zero("final_reset", 0);

    check("sb_drain", 0, 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
